// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the carry-resolve FSM states.
// Imported by both the upstream sum/carry stage and the iterative carry resolver.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/carry_step.sv
// One carry-propagation step: (s, c) -> (s ^ c<<1, s & c<<1) plus the bit shifted out of the top.
// Purely combinational, zero latency, no handshake.
module carry_step
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] s_nxt,
   output logic [WIDTH-1:0] c_nxt,
   output logic             dropped
);

   logic [WIDTH-1:0] sh;

   assign sh      = {c[WIDTH-2:0], 1'b0};
   assign s_nxt   = s ^ sh;
   assign c_nxt   = s & sh;
   // The top carry bit falls off the shift; it is the adder's carry-out.
   assign dropped = c[WIDTH-1];

endmodule

// File: rtl/carry_resolve_seq.sv
// Iterative carry resolver: turns a (sum, carry) pair into a+b, carry-out and step count.
// Latency 1+N cycles (N = carry chain length); accepts only in IDLE, holds result in DONE until out_ready.
module carry_resolve_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_in,
   input  logic [WIDTH-1:0] carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic [CNT_W-1:0] iters
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] s_step;
   logic [WIDTH-1:0] c_step;
   logic             dropped;
   logic             cout;
   logic [CNT_W-1:0] cnt;

   carry_step #(.WIDTH(WIDTH)) u_step (
      .s       (s),
      .c       (c),
      .s_nxt   (s_step),
      .c_nxt   (c_step),
      .dropped (dropped)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = (carry_in == '0) ? DONE : RESOLVE;
            end
         end
         RESOLVE: begin
            if (c_step == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s    <= '0;
         c    <= '0;
         cout <= 1'b0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s    <= sum_in;
                  c    <= carry_in;
                  cout <= 1'b0;
                  cnt  <= '0;
               end
            end
            RESOLVE: begin
               s    <= s_step;
               c    <= c_step;
               cout <= cout | dropped;
               cnt  <= cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Registers stay frozen outside RESOLVE, so DONE outputs are stable under backpressure.
   assign result    = s;
   assign carry_out = cout;
   assign iters     = cnt;

   // A carry can travel at most WIDTH positions before leaving the word.
   a_cnt_bound : assert property (@(posedge clk) disable iff (reset) cnt <= CNT_W'(WIDTH));

endmodule

// File: tb/tb_carry_resolve_seq.sv
// Bench for carry_resolve_seq: directed vectors plus a random stream checked
// every cycle against a generate/propagate chain-length model of the adder.
module tb_carry_resolve_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] sum_in = '0;
   logic [31:0] carry_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        carry_out;
   logic [5:0]  iters;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit done_rand = 1'b0;

   typedef struct {
      logic [32:0] total;
      int          n;
      int          acc;
   } exp_t;
   exp_t q[$];

   carry_resolve_seq dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_in    (sum_in),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .iters     (iters)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Steps needed = longest run of one generate bit followed by consecutive
   // propagate bits (each step moves every live carry up one position).
   function automatic int model_iters(input logic [31:0] p, input logic [31:0] g);
      int best;
      int len;
      best = 0;
      for (int i = 0; i < 32; i++) begin
         if (g[i]) begin
            len = 1;
            for (int j = i + 1; j < 32; j++) begin
               if (!p[j]) break;
               len++;
            end
            if (len > best) best = len;
         end
      end
      return best;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      bit   exp_ov;
      cyc++;
      if (reset) begin
         check("rst_in_ready", 64'(in_ready), 64'd1);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_result", 64'(result), 64'd0);
         check("rst_carry_out", 64'(carry_out), 64'd0);
         check("rst_iters", 64'(iters), 64'd0);
         q.delete();
      end else begin
         check("in_ready", 64'(in_ready), 64'(q.size() == 0));
         exp_ov = (q.size() != 0) && ((cyc - q[0].acc) >= 1 + q[0].n);
         check("out_valid", 64'(out_valid), 64'(exp_ov));
         check("iters_bound", 64'(iters <= 6'd32), 64'd1);
         if (out_valid && q.size() != 0) begin
            check("sum33", 64'({carry_out, result}), 64'(q[0].total));
            check("iters", 64'(iters), 64'(q[0].n));
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            e.total = 33'(sum_in) + {carry_in, 1'b0};
            e.n     = model_iters(sum_in, carry_in);
            e.acc   = cyc;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [31:0] s_v, input logic [31:0] c_v);
      bit ok;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      sum_in   = s_v;
      carry_in = c_v;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) timeout_fail("accept");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      bit ok;
      lat = 0;
      ok  = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         lat++;
         if (out_valid) ok = 1'b1;
      end
      if (!ok) timeout_fail("out_valid_wait");
   endtask

   task automatic directed(input string name, input logic [31:0] s_v, input logic [31:0] c_v,
                           input logic [31:0] exp_res, input logic exp_co,
                           input int exp_n, input int exp_lat);
      int lat;
      send(s_v, c_v);
      wait_out(lat);
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_result"}, 64'(result), 64'(exp_res));
      check({name, "_carry_out"}, 64'(carry_out), 64'(exp_co));
      check({name, "_iters"}, 64'(iters), 64'(exp_n));
   endtask

   initial begin
      int          lat;
      logic [31:0] a;
      logic [31:0] b;

      check("model_5p3", 64'(model_iters(32'h6, 32'h1)), 64'd3);
      check("model_ffp1", 64'(model_iters(32'hFFFF_FFFE, 32'h1)), 64'd32);
      check("model_nocarry", 64'(model_iters(32'h1234, 32'h0)), 64'd0);
      check("model_3p3", 64'(model_iters(32'h0, 32'h3)), 64'd1);

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      check("reset_iters", 64'(iters), 64'd0);
      reset = 1'b0;
      out_ready = 1'b1;

      directed("add_5_3", 32'h6, 32'h1, 32'h8, 1'b0, 3, 4);
      directed("no_carry", 32'h1234, 32'h0, 32'h1234, 1'b0, 0, 1);
      directed("ff_plus_1", 32'hFFFF_FFFE, 32'h1, 32'h0, 1'b1, 32, 33);
      directed("add_3_3", 32'h0, 32'h3, 32'h6, 1'b0, 1, 2);

      // Backpressure: result must sit still while out_ready is low.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(32'h6, 32'h1);
      wait_out(lat);
      check("bp_latency", 64'(lat), 64'd4);
      repeat (10) begin
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_result", 64'(result), 64'h8);
         check("bp_iters", 64'(iters), 64'd3);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("bp_after_in_ready", 64'(in_ready), 64'd1);
      check("bp_after_out_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of a long chain.
      send(32'hFFFF_FFFE, 32'h1);
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      directed("post_rst_5_3", 32'h6, 32'h1, 32'h8, 1'b0, 3, 4);

      fork
         begin
            for (int n = 0; n < 3000; n++) begin
               a = $urandom;
               b = $urandom;
               if (n % 40 == 0) begin
                  a = 32'hFFFF_FFFF;
                  b = 32'(1 + n % 3);
               end else if (n % 41 == 0) begin
                  b = ~a;
               end
               repeat ($urandom_range(0, 2)) @(posedge clk);
               send(a ^ b, a & b);
            end
            done_rand = 1'b1;
         end
         begin
            while (!done_rand) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join

      for (int k = 0; k < 500 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) timeout_fail("drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
